enc16x4_pending: RTL and testbench
==================================

Name: enc16x4_pending

Overview:
Registered 16-to-4 priority encoder with request latching. It is the encode-side counterpart of the 2x4/4x16 one-hot decoders.
- Request lines set sticky pending bits.
- The highest-index pending bit is presented as a 4-bit code with a valid/ack handshake.
- The acknowledged bit is then cleared.
- Sits between one-hot event sources and any consumer that needs a binary index, e.g. an interrupt/event encoder.

Parameters:
- N, 16, number of request lines.
- W, 4, code width; must equal clog2(N).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  request capture enable; when 0, din is ignored
- din  in  N  request lines; bit i high at a clk edge with en=1 sets pending[i]
- ack  in  1  consumer accepts the current code; effective only while valid=1
- dout  out  W  encoded index of the presented request
- valid  out  1  dout holds a live request
- pending  out  N  current pending register

Behaviour:
- Reset (rst_n=0, asynchronous): pending=0, dout=0, valid=0, state=IDLE. Recovery happens on the first clk edge after rst_n=1.
- Reset mid-handshake drops the presented code and all pending bits. There is no replay.
- Pending update on every edge: pending <= (pending & ~clr) | (en ? din : 0).
  - clr is one-hot of dout when state=HOLD and ack=1; otherwise clr is 0.
  - Set wins over clear: if din[dout]=1 with en=1 on the ack edge, that bit stays pending.
- Priority: highest index wins (bit 15 > bit 0), matching decoder output ordering.
- State IDLE (valid=0):
  - If pending != 0 at an edge: dout <= index of highest set bit in pending (register value before that edge), valid <= 1, go to HOLD.
  - Otherwise stay in IDLE; dout holds its last value.
- State HOLD (valid=1):
  - dout is frozen; newly pending higher-priority bits do not change it.
  - On an edge with ack=1: valid <= 0, go to IDLE.
  - On an edge with ack=0: hold.
- Ack with valid=0 is ignored and has no side effects.
- Latency:
  - din sampled at edge k → pending bit visible after edge k → valid=1 after edge k+1.
  - After an ack edge, valid is low for exactly one cycle before the next code, if any remains.
- Throughput: at most one code every 2 cycles.
- en=0: pending retained, handshake continues, ack still clears bits.
- din pulse and level are treated the same. A level held high re-sets the bit every cycle, so that code is re-presented after each ack.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Optional Feature:
Macro ENC_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit, reset 0).
  - Sticky; set on any edge where en=1 and din & pending != 0, i.e. a request arrives for a bit already pending and not being cleared that edge.
  - Cleared only by reset.
- Not defined: port absent and no overflow logic. All other behaviour is identical.

Decomposition:
- Package enc_pkg:
  - ENC_N=16, ENC_W=4.
  - State enum enc_state_t {ENC_IDLE, ENC_HOLD}.
- One sub-module, prio_enc16: purely combinational.
  - Inputs: N-bit vector.
  - Outputs: W-bit highest-set index and 1-bit any-set flag.
  - Instantiated once on the pending register.
- The top holds the pending register, state register, dout/valid registers and the optional overflow flag.

Test Plan:
1. Reset then single request: rst_n 0→1; din=16'h0010 with en=1 for one edge → pending=16'h0010 after that edge; valid=1, dout=4 one edge later; ack one edge → valid=0, pending=0.
2. Priority order and frozen code: din=16'h8001 with en=1 → dout=15. Then, while in HOLD, din=16'h4000 → dout remains 15. Ack → next presented dout=14, then 0, with one valid-low cycle between each.
3. Enable gating: en=0 with din=16'hFFFF for 5 cycles → pending stays 0, valid stays 0. Then en=1 for one edge → pending=16'hFFFF, dout=15.
4. Set-wins-over-clear: in HOLD with dout=3, assert ack and din=16'h0008 with en=1 on the same edge → pending[3] remains 1, and code 3 is presented again after the gap.
5. Asynchronous reset mid-operation: in HOLD with pending=16'h00F0, drop rst_n between edges → valid, dout and pending go to 0 immediately without a clock. Release → stays IDLE.
6. ENC_OVERFLOW_EN build: din=16'h0002 with en=1 on two consecutive edges without ack → overflow=1 after the second edge and stays 1 through ack; reset → overflow=0.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and constants for the 16-to-4 pending-request encoder.
//
// Contents:
//   ENC_N       - number of request lines (16)
//   ENC_W       - code width, clog2(ENC_N) (4)
//   enc_state_t - handshake state: ENC_IDLE (no code presented), ENC_HOLD (code presented)
//   enc_onehot  - expands a code back into a one-hot request mask
package enc_pkg;

  localparam int unsigned ENC_N = 16;
  localparam int unsigned ENC_W = 4;

  typedef enum logic [0:0] {
    ENC_IDLE = 1'b0,
    ENC_HOLD = 1'b1
  } enc_state_t;

  function automatic logic [ENC_N-1:0] enc_onehot(input logic [ENC_W-1:0] idx);
    logic [ENC_N-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/prio_enc16.sv
// Combinational highest-index-wins priority encoder.
//
// Parameters:
//   N - input vector width
//   W - index width, clog2(N)
// Ports:
//   vec  in  N  candidate bits
//   idx  out W  index of the highest set bit in vec (0 when vec is all zero)
//   any  out 1  at least one bit of vec is set
module prio_enc16
  import enc_pkg::*;
#(
  parameter int unsigned N = ENC_N,
  parameter int unsigned W = ENC_W
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Ascending scan: a later (higher) set bit overwrites an earlier one.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = W'(i);
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/enc16x4_pending.sv
// Registered 16-to-4 priority encoder with sticky request latching.
//
// Request lines set sticky pending bits. While no code is presented, the highest-index
// pending bit is registered into dout with valid=1; the code stays frozen until the
// consumer acks it, which clears that pending bit. After every ack valid is low for one
// cycle before the next code is presented.
//
// Optional build macro: ENC_OVERFLOW_EN adds a sticky overflow output flagging a request
// that arrived for a bit already pending (and not being cleared on that edge).
//
// Parameters:
//   N - number of request lines (16)
//   W - code width, clog2(N) (4)
// Ports:
//   clk      in  1  rising-edge clock
//   rst_n    in  1  asynchronous active-low reset
//   en       in  1  request capture enable
//   din      in  N  request lines
//   ack      in  1  consumer accepts dout (ignored while valid=0)
//   dout     out W  presented code
//   valid    out 1  dout holds a live request
//   pending  out N  pending register
//   overflow out 1  sticky re-request flag (ENC_OVERFLOW_EN only)
module enc16x4_pending
  import enc_pkg::*;
#(
  parameter int unsigned N = ENC_N,
  parameter int unsigned W = ENC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] din,
  input  logic         ack,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [N-1:0] pending
`ifdef ENC_OVERFLOW_EN
  ,
  output logic         overflow
`endif
);

  enc_state_t   state_q;
  logic [N-1:0] pending_q;
  logic [N-1:0] pending_d;
  logic [N-1:0] clr;
  logic [N-1:0] set;
  logic [W-1:0] hi_idx;
  logic         hi_any;

  // Encoder looks at the registered pending vector, so a request needs one edge to be
  // latched and a second edge to be presented.
  prio_enc16 #(
    .N(N),
    .W(W)
  ) u_prio (
    .vec(pending_q),
    .idx(hi_idx),
    .any(hi_any)
  );

  // Only the presented code is cleared, and only on an accepted handshake.
  always_comb begin
    clr = '0;
    if (state_q == ENC_HOLD && ack) begin
      clr = enc_onehot(dout);
    end
  end

  assign set = en ? din : '0;

  // Set is applied after clear so a re-request on the ack edge keeps the bit pending.
  assign pending_d = (pending_q & ~clr) | set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Handshake FSM with registered dout/valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENC_IDLE;
      dout    <= '0;
      valid   <= 1'b0;
    end else begin
      unique case (state_q)
        ENC_IDLE: begin
          if (hi_any) begin
            dout    <= hi_idx;
            valid   <= 1'b1;
            state_q <= ENC_HOLD;
          end
        end
        ENC_HOLD: begin
          if (ack) begin
            valid   <= 1'b0;
            state_q <= ENC_IDLE;
          end
        end
        default: begin
          state_q <= ENC_IDLE;
          valid   <= 1'b0;
        end
      endcase
    end
  end

  assign pending = pending_q;

`ifdef ENC_OVERFLOW_EN
  // A request hitting a bit that survives this edge's clear has been lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (en && |(din & pending_q & ~clr)) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_enc16x4_pending.sv
// Self-checking bench for enc16x4_pending: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of the pending set and handshake.
module tb_enc16x4_pending;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] din;
  logic        ack;
  logic [3:0]  dout;
  logic        valid;
  logic [15:0] pending;
`ifdef ENC_OVERFLOW_EN
  logic        overflow;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [15:0] m_pend;
  bit          m_valid;
  int          m_code;
  bit          m_ovf;

  enc16x4_pending dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .din(din),
    .ack(ack),
    .dout(dout),
    .valid(valid),
    .pending(pending)
`ifdef ENC_OVERFLOW_EN
    ,
    .overflow(overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int highest(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_valid = 0;
    m_code  = 0;
    m_ovf   = 0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge model values.
  task automatic model_edge(input logic e, input logic [15:0] d, input logic a);
    logic [15:0] cleared;
    cleared = m_pend;
    if (m_valid && a) cleared[m_code] = 1'b0;
    if (e && ((d & cleared) != 0)) m_ovf = 1;
    if (!m_valid) begin
      if (m_pend != 0) begin
        m_code  = highest(m_pend);
        m_valid = 1;
      end
    end else if (a) begin
      m_valid = 0;
    end
    m_pend = cleared | (e ? d : 16'h0);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pending"}, pending, m_pend);
    check({tag, ".valid"}, valid, m_valid);
    check({tag, ".dout"}, dout, m_code);
`ifdef ENC_OVERFLOW_EN
    check({tag, ".overflow"}, overflow, m_ovf);
`endif
  endtask

  // Drive at negedge, advance one posedge, check 1ns later, return at next negedge.
  task automatic step(input string tag, input logic e, input logic [15:0] d, input logic a);
    en  = e;
    din = d;
    ack = a;
    @(posedge clk);
    model_edge(e, d, a);
    #1;
    check_model(tag);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    din   = '0;
    ack   = 1'b0;
    model_reset();
    #2;
    check_model("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. single request
    step("t1.latch", 1'b1, 16'h0010, 1'b0);
    check("t1.pend_const", pending, 16'h0010);
    check("t1.valid_lo", valid, 1'b0);
    step("t1.present", 1'b0, 16'h0000, 1'b0);
    check("t1.dout_const", dout, 4'd4);
    step("t1.ack", 1'b0, 16'h0000, 1'b1);
    check("t1.cleared", pending, 16'h0000);

    // 2. priority and frozen code
    step("t2.latch", 1'b1, 16'h8001, 1'b0);
    step("t2.present", 1'b0, 16'h0000, 1'b0);
    check("t2.dout15", dout, 4'd15);
    step("t2.frozen", 1'b1, 16'h4000, 1'b0);
    check("t2.frozen15", dout, 4'd15);
    step("t2.ack15", 1'b0, 16'h0000, 1'b1);
    check("t2.gap1", valid, 1'b0);
    step("t2.present14", 1'b0, 16'h0000, 1'b0);
    check("t2.dout14", dout, 4'd14);
    step("t2.ack14", 1'b0, 16'h0000, 1'b1);
    step("t2.present0", 1'b0, 16'h0000, 1'b0);
    check("t2.dout0", dout, 4'd0);
    step("t2.ack0", 1'b0, 16'h0000, 1'b1);
    check("t2.empty", pending, 16'h0000);

    // 3. enable gating
    for (int i = 0; i < 5; i++) step("t3.gated", 1'b0, 16'hFFFF, 1'b0);
    check("t3.gated_pend", pending, 16'h0000);
    step("t3.open", 1'b1, 16'hFFFF, 1'b0);
    check("t3.all_pend", pending, 16'hFFFF);
    step("t3.present", 1'b0, 16'h0000, 1'b0);
    check("t3.dout15", dout, 4'd15);
    for (int i = 0; i < 16; i++) begin
      step("t3.drain_ack", 1'b0, 16'h0000, 1'b1);
      step("t3.drain_next", 1'b0, 16'h0000, 1'b0);
    end
    check("t3.drained", pending, 16'h0000);

    // 4. set wins over clear
    step("t4.latch", 1'b1, 16'h0008, 1'b0);
    step("t4.present", 1'b0, 16'h0000, 1'b0);
    check("t4.dout3", dout, 4'd3);
    step("t4.ack_set", 1'b1, 16'h0008, 1'b1);
    check("t4.kept", pending, 16'h0008);
    step("t4.again", 1'b0, 16'h0000, 1'b0);
    check("t4.again3", dout, 4'd3);
    step("t4.ack", 1'b0, 16'h0000, 1'b1);

    // 5. asynchronous reset mid-handshake
    step("t5.latch", 1'b1, 16'h00F0, 1'b0);
    step("t5.present", 1'b0, 16'h0000, 1'b0);
    check("t5.dout7", dout, 4'd7);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("t5.async");
    @(negedge clk);
    rst_n = 1'b1;
    step("t5.idle1", 1'b0, 16'h0000, 1'b0);
    step("t5.idle2", 1'b0, 16'h0000, 1'b1);

`ifdef ENC_OVERFLOW_EN
    // 6. overflow
    step("t6.first", 1'b1, 16'h0002, 1'b0);
    check("t6.no_ovf", overflow, 1'b0);
    step("t6.second", 1'b1, 16'h0002, 1'b0);
    check("t6.ovf", overflow, 1'b1);
    step("t6.present", 1'b0, 16'h0000, 1'b0);
    step("t6.ack", 1'b0, 16'h0000, 1'b1);
    check("t6.ovf_sticky", overflow, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6.ovf_reset", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Randomized traffic with sparse requests
    for (int i = 0; i < 400; i++) begin
      logic        e;
      logic [15:0] d;
      logic        a;
      e = ($urandom_range(0, 3) != 0);
      d = 16'($urandom & $urandom & $urandom);
      a = 1'($urandom_range(0, 1));
      step("rand", e, d, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
